// File: rtl/ps_result_tx_pkg.sv
// ps_result_tx_pkg
//   Shared types and constants for the PS result mailbox transmitter.
//   - DATA_W  : width of one result word / channel data register
//   - state_e : handshake FSM states
//   - chan_w(): width of a channel index for a given channel count (min 1)
package ps_result_tx_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ps_result_tx_fifo.sv
// ps_result_tx_fifo
//   Synchronous FIFO buffering {chan, data} entries ahead of the handshake FSM.
//   The head entry is held in a register (no fall-through): a push into an
//   empty FIFO makes the word visible on head_o one edge later.
// Ports:
//   CLK, RESETN    : clock, asynchronous active-low reset
//   push_i/wdata_i : write request and entry (ignored while full)
//   pop_i          : consume the head entry (ignored while empty)
//   head_o         : current head entry, valid while !empty_o
//   empty_o        : no entries stored
//   ready_o        : registered "not full", low while in reset
//   level_o        : registered occupancy
//   level_next_o   : occupancy after the coming edge
module ps_result_tx_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RESETN,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     empty_o,
    output logic                     ready_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [$clog2(DEPTH):0]   level_next_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_inc;
    logic [LVL_W-1:0] count_q, count_d;
    logic             ready_q;
    logic             do_push, do_pop, head_from_wr;

    assign do_push    = push_i && (count_q != LVL_W'(DEPTH));
    assign do_pop     = pop_i && (count_q != '0);
    assign rd_ptr_inc = rd_ptr_q + PTR_W'(1);
    // The incoming word becomes the head when nothing else would be there
    // after this edge: FIFO empty, or its only entry is being popped.
    assign head_from_wr = do_push &&
                          ((count_q == '0) || (do_pop && (count_q == LVL_W'(1))));

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage and head register: no reset so the array maps onto RAM.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
        if (head_from_wr) begin
            head_q <= wdata_i;
        end else if (do_pop) begin
            head_q <= mem_q[rd_ptr_inc];
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ready_q  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_inc;
            end
            count_q <= count_d;
            ready_q <= (count_d != LVL_W'(DEPTH));
        end
    end

    assign head_o       = head_q;
    assign empty_o      = (count_q == '0);
    assign ready_o      = ready_q;
    assign level_o      = count_q;
    assign level_next_o = count_d;

endmodule

// File: rtl/ps_result_tx.sv
// ps_result_tx
//   PL-side transmitter for the PS result mailbox. Result words arrive on a
//   valid/ready stream, are buffered in a FIFO and delivered one at a time on
//   a per-channel data register with a four-phase intr/ack handshake.
//   Optional feature macro: PS_RESULT_TX_TIMEOUT_EN (abandon a word when no
//   acknowledge arrives within ACK_TIMEOUT cycles).
// Ports:
//   CLK, RESETN        : clock, asynchronous active-low reset
//   s_valid/s_ready    : input stream handshake (s_ready = !full, 0 in reset)
//   s_data, s_chan     : result word and target channel
//   data_out           : packed channel registers, channel k at [32k+31:32k]
//   intr_out, intr_ack : request / acknowledge per channel
//   clr_err            : clears the sticky error flags
//   err_chan           : sticky, a word addressed a nonexistent channel
//   err_timeout        : sticky, an acknowledge timed out
//   busy               : FIFO non-empty or a handshake in progress
//   fifo_level         : FIFO occupancy
module ps_result_tx
    import ps_result_tx_pkg::*;
#(
    parameter int number_outputs = 3,
    parameter int FIFO_DEPTH     = 8,
    parameter int ACK_TIMEOUT    = 1024
) (
    input  logic                                CLK,
    input  logic                                RESETN,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [DATA_W-1:0]                   s_data,
    input  logic [chan_w(number_outputs)-1:0]   s_chan,
    output logic [number_outputs*DATA_W-1:0]    data_out,
    output logic [number_outputs-1:0]           intr_out,
    input  logic [number_outputs-1:0]           intr_ack,
    input  logic                                clr_err,
    output logic                                err_chan,
    output logic                                err_timeout,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH):0]         fifo_level
);

    localparam int CHAN_W  = chan_w(number_outputs);
    localparam int LVL_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int ENTRY_W = CHAN_W + DATA_W;

    if (number_outputs < 1 || number_outputs > 16 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || ACK_TIMEOUT < 1) begin : g_cfg_check
        $error("ps_result_tx: unsupported parameter set");
    end

    // ------------------------------------------------------------------
    // Input buffer
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0] fifo_head;
    logic               fifo_empty, fifo_pop;
    logic [LVL_W-1:0]   level_next;
    logic [CHAN_W-1:0]  head_chan;
    logic [DATA_W-1:0]  head_data;

    ps_result_tx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .push_i       (s_valid && s_ready),
        .wdata_i      ({s_chan, s_data}),
        .pop_i        (fifo_pop),
        .head_o       (fifo_head),
        .empty_o      (fifo_empty),
        .ready_o      (s_ready),
        .level_o      (fifo_level),
        .level_next_o (level_next)
    );

    assign head_chan = fifo_head[ENTRY_W-1:DATA_W];
    assign head_data = fifo_head[DATA_W-1:0];

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    state_e                    state_q, state_d;
    logic [CHAN_W-1:0]         chan_q, chan_d;
    logic [number_outputs-1:0] intr_q, intr_d;
    logic [DATA_W-1:0]         data_q [number_outputs];
    logic [DATA_W-1:0]         data_d [number_outputs];
    logic                      err_chan_q, err_chan_d, err_chan_set;
    logic                      busy_q, busy_d;
    logic                      ack_sel;

    // Acknowledge of the latched channel only; other channels are ignored.
    always_comb begin
        ack_sel = 1'b0;
        for (int k = 0; k < number_outputs; k++) begin
            if (int'(chan_q) == k) begin
                ack_sel = intr_ack[k];
            end
        end
    end

`ifdef PS_RESULT_TX_TIMEOUT_EN
    localparam int TO_W = $clog2(ACK_TIMEOUT) + 1;

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            err_to_q, err_to_d, to_set;

    // Counts cycles spent in REQ; it sits at zero elsewhere, so it is
    // already cleared on every REQ entry.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_REQ) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            to_cnt_q <= '0;
            err_to_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            err_to_q <= err_to_d;
        end
    end

    assign err_to_d    = to_set ? 1'b1 : (clr_err ? 1'b0 : err_to_q);
    assign err_timeout = err_to_q;
`else
    assign err_timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        chan_d       = chan_q;
        intr_d       = intr_q;
        data_d       = data_q;
        fifo_pop     = 1'b0;
        err_chan_set = 1'b0;
`ifdef PS_RESULT_TX_TIMEOUT_EN
        to_set       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (int'(head_chan) < number_outputs) begin
                        intr_d = '0;
                        for (int k = 0; k < number_outputs; k++) begin
                            if (int'(head_chan) == k) begin
                                data_d[k] = head_data;
                                intr_d[k] = 1'b1;
                            end
                        end
                        chan_d  = head_chan;
                        state_d = ST_REQ;
                    end else begin
                        err_chan_set = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (ack_sel) begin
                    intr_d  = '0;
                    state_d = ST_RELEASE;
                end
`ifdef PS_RESULT_TX_TIMEOUT_EN
                else if (to_cnt_q == TO_W'(ACK_TIMEOUT - 1)) begin
                    // Abandon the word; skip RELEASE since no ack is pending.
                    intr_d  = '0;
                    to_set  = 1'b1;
                    state_d = ST_IDLE;
                end
`endif
            end
            ST_RELEASE: begin
                if (!ack_sel) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                intr_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign err_chan_d = err_chan_set ? 1'b1 : (clr_err ? 1'b0 : err_chan_q);
    assign busy_d     = (level_next != '0) || (state_d != ST_IDLE);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q    <= ST_IDLE;
            chan_q     <= '0;
            intr_q     <= '0;
            err_chan_q <= 1'b0;
            busy_q     <= 1'b0;
            for (int k = 0; k < number_outputs; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            intr_q     <= intr_d;
            err_chan_q <= err_chan_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
        end
    end

    for (genvar gi = 0; gi < number_outputs; gi++) begin : g_data_out
        assign data_out[gi*DATA_W +: DATA_W] = data_q[gi];
    end

    assign intr_out = intr_q;
    assign err_chan = err_chan_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_ps_result_tx.sv
module tb_ps_result_tx;

    localparam int N     = 3;
    localparam int DEPTH = 8;
`ifdef PS_RESULT_TX_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 1024;
`endif

    logic          CLK;
    logic          RESETN;
    logic          s_valid;
    logic          s_ready;
    logic [31:0]   s_data;
    logic [1:0]    s_chan;
    logic [N*32-1:0] data_out;
    logic [N-1:0]  intr_out;
    logic [N-1:0]  intr_ack;
    logic          clr_err;
    logic          err_chan;
    logic          err_timeout;
    logic          busy;
    logic [3:0]    fifo_level;

    ps_result_tx #(
        .number_outputs (N),
        .FIFO_DEPTH     (DEPTH),
        .ACK_TIMEOUT    (TO)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_chan      (s_chan),
        .data_out    (data_out),
        .intr_out    (intr_out),
        .intr_ack    (intr_ack),
        .clr_err     (clr_err),
        .err_chan    (err_chan),
        .err_timeout (err_timeout),
        .busy        (busy),
        .fifo_level  (fifo_level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        int          ch;
        logic [31:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int ch, input logic [31:0] d);
        exp_t e;
        check("push_ready", s_ready, 1'b1);
        s_valid = 1'b1;
        s_chan  = 2'(ch);
        s_data  = d;
        if (ch < N) begin
            e.ch = ch;
            e.d  = d;
            exp_q.push_back(e);
        end
        $display("push ch=%0d data=0x%08h", ch, d);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic wait_intr(output int ch);
        ch = -1;
        for (int i = 0; i < 2000 && intr_out == '0; i++) begin
            tick();
        end
        if (intr_out == '0) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_intr: no interrupt within 2000 cycles, got 0x%0h, expected nonzero", intr_out);
        end else begin
            for (int k = 0; k < N; k++) begin
                if (intr_out[k]) ch = k;
            end
        end
    endtask

    // PS model: wait for a request, ack after dly cycles for one cycle, release.
    task automatic ack_word(input int dly);
        int ch;
        wait_intr(ch);
        if (ch >= 0) begin
            repeat (dly) tick();
            intr_ack[ch] = 1'b1;
            tick();
            check("intr_drop_after_ack", intr_out, 0);
            intr_ack[ch] = 1'b0;
            tick();
        end
    endtask

    // Scoreboard monitor: each new interrupt is one delivered word.
    initial begin
        logic [N-1:0] prev;
        exp_t         e;
        int           ch;
        prev = '0;
        forever begin
            @(negedge CLK);
            if (RESETN && prev == '0 && intr_out != '0) begin
                ch = 0;
                for (int k = 0; k < N; k++) begin
                    if (intr_out[k]) ch = k;
                end
                $display("deliver ch=%0d data=0x%08h", ch, data_out[ch*32 +: 32]);
                check("intr_onehot", $countones(intr_out), 1);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_delivery: got ch=%0d, expected no delivery", ch);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver_chan", ch, e.ch);
                    check("deliver_data", data_out[ch*32 +: 32], e.d);
                end
            end
            prev = intr_out;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        RESETN   = 1'b0;
        s_valid  = 1'b0;
        s_data   = '0;
        s_chan   = '0;
        intr_ack = '0;
        clr_err  = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_s_ready", s_ready, 0);
        check("rst_intr", intr_out, 0);
        check("rst_data", data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_level", fifo_level, 0);
        check("rst_err", {err_chan, err_timeout}, 0);
        RESETN = 1'b1;
        repeat (2) tick();
        check("ready_after_rst", s_ready, 1);

        // Single word, exact latency
        push(2, 32'hDEADBEEF);
        check("single_intr_n", intr_out, 0);
        check("single_level_n", fifo_level, 1);
        tick();
        check("single_intr_n1", intr_out, 3'b100);
        check("single_data_n1", data_out[95:64], 32'hDEADBEEF);
        check("single_level_n1", fifo_level, 0);
        check("single_busy_n1", busy, 1);
        repeat (2) tick();
        check("single_intr_hold", intr_out, 3'b100);
        intr_ack[2] = 1'b1;
        tick();
        check("single_intr_drop", intr_out, 0);
        intr_ack[2] = 1'b0;
        tick();
        check("single_busy_idle", busy, 0);

        // Burst until full, refused push, in-order delivery
        for (int i = 0; i < 9; i++) begin
            push(i % 3, 32'h1000_0000 + i);
        end
        check("burst_level_full", fifo_level, 8);
        check("burst_ready_low", s_ready, 0);
        check("burst_req_ch0", intr_out, 3'b001);
        s_valid = 1'b1;
        s_chan  = 2'd1;
        s_data  = 32'hBADBAD00;
        tick();
        s_valid = 1'b0;
        check("burst_refused_level", fifo_level, 8);
        for (int i = 0; i < 9; i++) begin
            ack_word(0);
        end
        check("burst_level_empty", fifo_level, 0);
        check("burst_busy_idle", busy, 0);
        check("burst_data_hold", data_out, {32'h1000_0008, 32'h1000_0007, 32'h1000_0006});

        // Bad channel; error set wins over a simultaneous clear
        push(3, 32'hBAD0BAD0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("badch_err_set_wins", err_chan, 1);
        check("badch_no_intr", intr_out, 0);
        push(1, 32'h11111111);
        ack_word(1);
        check("badch_err_sticky", err_chan, 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("badch_err_cleared", err_chan, 0);

        // Ack on another channel is ignored
        push(0, 32'hA5A5A5A5);
        tick();
        intr_ack[1] = 1'b1;
        tick();
        intr_ack[1] = 1'b0;
        check("wrongack_intr_hold", intr_out, 3'b001);
        tick();
        check("wrongack_intr_hold2", intr_out, 3'b001);
        ack_word(0);

`ifdef PS_RESULT_TX_TIMEOUT_EN
        // Timeout: never ack the first word
        push(2, 32'hC0C0C0C0);
        push(1, 32'h0D0D0D0D);
        hi = 0;
        for (int i = 0; i < 100 && intr_out == 3'b100; i++) begin
            hi++;
            tick();
        end
        check("timeout_high_cycles", hi, TO);
        check("timeout_intr_low", intr_out, 0);
        check("timeout_err", err_timeout, 1);
        ack_word(0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        check("timeout_err_cleared", err_timeout, 0);
`else
        // No timeout: request held indefinitely
        push(2, 32'hC0C0C0C0);
        hi = 0;
        repeat (1000) tick();
        check("notimeout_intr_hold", intr_out, 3'b100);
        check("notimeout_data", data_out[95:64], 32'hC0C0C0C0);
        check("notimeout_err", err_timeout, 0);
        ack_word(0);
`endif

        // Asynchronous reset mid-REQ with three words buffered
        push(0, 32'h00000001);
        push(1, 32'h00000002);
        push(2, 32'h00000003);
        push(0, 32'h00000004);
        check("rstmid_level", fifo_level, 3);
        check("rstmid_req", intr_out, 3'b001);
        #3;
        RESETN = 1'b0;
        #1;
        exp_q.delete();
        check("rstmid_intr", intr_out, 0);
        check("rstmid_data", data_out, 0);
        check("rstmid_ready", s_ready, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_level0", fifo_level, 0);
        tick();
        RESETN = 1'b1;
        repeat (20) tick();
        check("rstmid_after_level", fifo_level, 0);
        check("rstmid_after_intr", intr_out, 0);
        check("rstmid_after_busy", busy, 0);
        check("rstmid_after_ready", s_ready, 1);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps_result_tx.md
# ps_result_tx

PL-side transmitter for the PS result mailbox: it accepts result words from the RO measurement logic over a valid/ready stream and delivers each one on a per-channel 32-bit data register with a four-phase interrupt/acknowledge handshake toward the processing system. It sits between the measurement core and the block design's serial input bus (`number_outputs` × 32 bits plus one interrupt line per channel). It buffers bursts in a small FIFO so the measurement core is never stalled by PS software latency.

## Interface
- `number_outputs`, 3, number of PS-facing channels (1..16)
- `FIFO_DEPTH`, 8, entries in the input buffer; power of two, ≥2
- `ACK_TIMEOUT`, 1024, cycles to wait for acknowledge before abandoning a word (timeout builds only)

- `CLK`  in  1  single clock for the whole block; the PS fabric clock
- `RESETN`  in  1  asynchronous, active-low reset
- `s_valid`  in  1  input word valid
- `s_ready`  out  1  input buffer can accept; equals !full
- `s_data`  in  32  result word
- `s_chan`  in  clog2(number_outputs) (min 1)  target channel
- `data_out`  out  number_outputs*32  channel registers, packed; channel k at [32k+31:32k]
- `intr_out`  out  number_outputs  request line per channel toward the PS
- `intr_ack`  in  number_outputs  acknowledge per channel from the PS
- `clr_err`  in  1  one-cycle pulse that clears the sticky error flags
- `err_chan`  out  1  sticky: a word addressed a channel ≥ number_outputs
- `err_timeout`  out  1  sticky: an acknowledge timed out
- `busy`  out  1  FIFO non-empty or FSM not IDLE
- `fifo_level`  out  clog2(FIFO_DEPTH)+1  current occupancy

## Operation
- Push: when `s_valid && s_ready` at an edge, `{s_chan, s_data}` is written. When the FIFO is full, `s_ready` is 0 and no push occurs, even if a pop happens in the same cycle.
- FSM states: IDLE, REQ, RELEASE.
- IDLE, FIFO non-empty: pop the head entry.
  - Channel in range: load `data_out[chan]`, assert `intr_out[chan]`, latch chan, go to REQ.
  - Channel out of range: discard the word, set `err_chan`, stay in IDLE.
- REQ: hold `intr_out[chan]` high and `data_out` stable. When `intr_ack[chan]` is 1, drop `intr_out[chan]` and go to RELEASE. Acks on other channels are ignored.
- RELEASE: wait for `intr_ack[chan]` to return to 0, then go to IDLE. Only then may the next word be popped.
- At most one `intr_out` bit is high at any time.
- `data_out` channels hold their last value until overwritten.
- `clr_err` clears both sticky flags. If an error event occurs in the same cycle as `clr_err`, the flag ends set (the set has priority).
- Reset (asserted at any time, including mid-handshake):
  - FSM goes to IDLE and the FIFO is emptied.
  - `data_out` = 0, `intr_out` = 0, `s_ready` = 0 while reset is asserted, then 1.
  - `err_*` = 0, `busy` = 0, `fifo_level` = 0.
  - The interrupted word is lost.

## Timing
- All outputs are registered. `s_ready` and `fifo_level` reflect occupancy after the current edge.
- Latency: word accepted at edge N into an empty FIFO with the FSM in IDLE → `data_out[chan]` and `intr_out[chan]` both change at edge N+1. Data is therefore valid whenever the interrupt is high.
- Ack seen high at edge M → `intr_out` is low after edge M.
- Ack seen low in RELEASE at edge P → the next pop may occur at edge P+1.
- Minimum per-word cycle: 3 clocks (ack high for 1 cycle, low the next).
- Throughput into the FIFO: 1 word/cycle until full.

## Configuration
- `PS_RESULT_TX_TIMEOUT_EN` defined:
  - A counter runs in REQ (width clog2(ACK_TIMEOUT)+1), cleared on REQ entry.
  - On the ACK_TIMEOUT-th cycle without ack: drop `intr_out`, set `err_timeout`, go directly to IDLE (RELEASE is skipped). The word is counted as delivered.
- Not defined: REQ waits indefinitely, no counter is built, and `err_timeout` is tied to 0.

## Structure
- Package `ps_result_tx_pkg`: state enum (IDLE, REQ, RELEASE), `CHAN_W` derivation function, and `DATA_W = 32`.
- Sub-module `ps_result_tx_fifo`: synchronous FIFO, width CHAN_W+32, depth FIFO_DEPTH, async active-low reset, full/empty/level outputs. No first-word fall-through; the head is registered.

## Test plan
- Single word: push 0xDEADBEEF to channel 2, ack 2 cycles after the interrupt, release 1 cycle later → `data_out[95:64]` = 0xDEADBEEF and `intr_out` = 3'b100 from edge N+1 until the ack is seen; `busy` returns to 0.
- Burst/full: push 9 words with no ack and FIFO_DEPTH 8 → 1 word in REQ and 8 in the FIFO, `s_ready` = 0 and the 10th push is refused. Acking each word in turn delivers all words in order.
- Bad channel: push chan=3 (number_outputs=3), then a valid word → `err_chan` = 1, no interrupt for the bad word, the valid word is delivered. `clr_err` then returns `err_chan` to 0.
- Wrong-channel ack: REQ on channel 0 while `intr_ack[1]` pulses → no state change; a subsequent `intr_ack[0]` completes the handshake.
- Timeout (macro defined, ACK_TIMEOUT=16): never ack → `intr_out` falls after 16 cycles, `err_timeout` = 1, the next word is issued. Without the macro, `intr_out` is still high after 1000 cycles.
- Reset mid-REQ: assert RESETN=0 with 3 words buffered → all outputs go to their reset values asynchronously. After release, `fifo_level` = 0 and no interrupt occurs.
